// File: rtl/mesh_edge_injector.sv
// mesh_edge_injector: boundary injector for one mesh edge input port.
// Host packets are queued in a small FIFO, then serialized MS-flit first
// into the adjacent cell's data/write-enable pair, with the cell's full
// flag as backpressure. Back-to-back packets are streamed without bubbles.
module mesh_edge_injector #(
  parameter int unsigned FLIT_W     = 4,
  parameter int unsigned PKT_FLITS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rt_reset,
  input  logic [FLIT_W*PKT_FLITS-1:0] pkt_in,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        flit_en,
  input  logic                        cell_full,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int unsigned PKT_W = FLIT_W * PKT_FLITS;
  localparam int unsigned IDX_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam int unsigned OCC_W = FIFO_AW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // Packet FIFO
  // ---------------------------------------------------------------------
  logic [PKT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [OCC_W-1:0]   occ_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [PKT_W-1:0]   fifo_head;

  assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign pkt_ready  = !fifo_full && !rt_reset;
  assign push       = pkt_valid && pkt_ready;

  // Storage array: written on push only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pkt_in;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keep occupancy.
  always_ff @(posedge clk) begin
    if (rt_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [PKT_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FLIT_W-1:0] flit_out_c;
  logic              flit_en_c;

  // State, shift register, flit index and packet counter.
  always_ff @(posedge clk) begin
    if (rt_reset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, FIFO pop and flit outputs; the last accepted flit may
  // reload the next packet in the same edge to avoid an idle cycle.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    flit_out_c = '0;
    flit_en_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sreg_d  = fifo_head;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        flit_out_c = sreg_q[PKT_W-1 -: FLIT_W];
        flit_en_c  = !cell_full;
        if (!cell_full) begin
          sreg_d = sreg_q << FLIT_W;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(PKT_FLITS - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            if (!fifo_empty) begin
              pop    = 1'b1;
              sreg_d = fifo_head;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Cell-facing outputs are silenced while reset is held so an abandoned
  // packet never gets another strobe.
  assign flit_out  = rt_reset ? '0 : flit_out_c;
  assign flit_en   = flit_en_c && !rt_reset;
  assign busy      = !rt_reset && ((state_q == S_SEND) || !fifo_empty);
  assign pkt_count = cnt_q;

endmodule
